// File: rtl/cyclic_decoder_meggitt_if.sv
// Serial bit-stream bundle for the (15,11) Meggitt decoder: codeword in, corrected data out.
interface cyclic_decoder_meggitt_if;
    logic in_valid;
    logic in;
    logic in_ready;
    logic out_valid;
    logic out;
    logic err_detected;
    logic err_corrected;

    modport master (
        output in_valid, in,
        input  in_ready, out_valid, out, err_detected, err_corrected
    );

    modport slave (
        input  in_valid, in,
        output in_ready, out_valid, out, err_detected, err_corrected
    );
endinterface

// File: rtl/cyclic_decoder_meggitt.sv
// Meggitt decoder for the systematic (15,11) cyclic Hamming code, g(x) = x^4 + x + 1.
// Receives 15 bits MSB-first, then streams 11 corrected data bits with error status.
module cyclic_decoder_meggitt (
    input  logic clk,
    input  logic rst,
    cyclic_decoder_meggitt_if.slave bus
);
    localparam int unsigned N         = 15;
    localparam int unsigned K         = 11;
    localparam logic [3:0]  GEN_LOW   = 4'b0011;
    localparam logic [3:0]  MATCH     = 4'b1001;
    localparam logic [3:0]  LAST_RECV = 4'(N - 1);
    localparam logic [3:0]  LAST_SEND = 4'(K - 1);

    typedef enum logic {StRecv, StSend} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   shift_q, shift_d;
    logic [3:0]     syn_q, syn_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           syn_nz_q, syn_nz_d;
    logic           corr_q, corr_d;
    logic           match;

    // One LFSR step of the syndrome register: multiply by x, feed bit b, reduce mod g.
    function automatic logic [3:0] syn_step(input logic [3:0] s, input logic b);
        return {s[2:0], b} ^ (s[3] ? GEN_LOW : 4'b0000);
    endfunction

    always_comb begin
        state_d           = state_q;
        shift_d           = shift_q;
        syn_d             = syn_q;
        cnt_d             = cnt_q;
        syn_nz_d          = syn_nz_q;
        corr_d            = corr_q;
        match             = 1'b0;
        bus.in_ready      = 1'b0;
        bus.out_valid     = 1'b0;
        bus.out           = 1'b0;
        bus.err_detected  = 1'b0;
        bus.err_corrected = 1'b0;

        unique case (state_q)
            StRecv: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    shift_d = {shift_q[N-2:0], bus.in};
                    syn_d   = syn_step(syn_q, bus.in);
                    if (cnt_q == LAST_RECV) begin
                        state_d  = StSend;
                        cnt_d    = 4'd0;
                        syn_nz_d = (syn_d != 4'd0);
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StSend: begin
                bus.out_valid = 1'b1;
                match         = (syn_q == MATCH);
                bus.out       = shift_q[N-1] ^ match;
                shift_d       = {shift_q[N-2:0], 1'b0};
                if (match) begin
                    syn_d  = 4'd0;
                    corr_d = 1'b1;
                end else begin
                    syn_d = syn_step(syn_q, 1'b0);
                end
                if (cnt_q == LAST_SEND) begin
                    // A correction on the final data bit must still show in this pulse.
                    bus.err_detected  = syn_nz_q;
                    bus.err_corrected = corr_q | match;
                    state_d           = StRecv;
                    syn_d             = 4'd0;
                    cnt_d             = 4'd0;
                    syn_nz_d          = 1'b0;
                    corr_d            = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StRecv;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRecv;
            shift_q  <= '0;
            syn_q    <= 4'd0;
            cnt_q    <= 4'd0;
            syn_nz_q <= 1'b0;
            corr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            syn_q    <= syn_d;
            cnt_q    <= cnt_d;
            syn_nz_q <= syn_nz_d;
            corr_q   <= corr_d;
        end
    end
endmodule

// File: tb/tb_cyclic_decoder_meggitt.sv
// Randomized self-checking bench for cyclic_decoder_meggitt against a polynomial-division model.
module tb_cyclic_decoder_meggitt;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    cyclic_decoder_meggitt_if bus ();

    cyclic_decoder_meggitt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // r(x) mod g(x) by long division.
    function automatic logic [3:0] poly_mod(input logic [14:0] r);
        logic [14:0] t;
        logic [14:0] g;
        t = r;
        for (int d = 14; d >= 4; d--) begin
            g = 15'b000000000010011 << (d - 4);
            if (t[d]) t = t ^ g;
        end
        return t[3:0];
    endfunction

    // Degree of the single-bit error pattern with this syndrome, -1 if none.
    function automatic int err_pos(input logic [3:0] syn);
        logic [14:0] e;
        for (int p = 0; p < 15; p++) begin
            e = 15'(1) << p;
            if (syn != 4'd0 && poly_mod(e) == syn) return p;
        end
        return -1;
    endfunction

    function automatic logic [14:0] encode(input logic [10:0] data);
        logic [14:0] shifted;
        shifted = {data, 4'b0000};
        return {data, poly_mod(shifted)};
    endfunction

    task automatic send_bits(input logic [14:0] cw, input int nbits, input bit gaps,
                             input bit hold);
        logic rdy;
        bit   ok;
        for (int i = 14; i > 14 - nbits; i--) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.in       = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in       = cw[i];
            ok = 1'b0;
            for (int w = 0; w < 30; w++) begin
                rdy = bus.in_ready;
                @(posedge clk);
                #1;
                if (rdy) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                check_eq("accept_timeout", 32'(ok), 32'd1);
                break;
            end
        end
        bus.in_valid = hold;
        bus.in       = 1'($urandom);
    endtask

    task automatic collect(output logic [10:0] data, output logic det, output logic cor,
                           output int nval, output int bad, output logic ready);
        data  = '0;
        det   = 1'b0;
        cor   = 1'b0;
        nval  = 0;
        bad   = 0;
        ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                data = {data[9:0], bus.out};
                nval++;
                if (nval == 11) begin
                    det          = bus.err_detected;
                    cor          = bus.err_corrected;
                    bus.in_valid = 1'b0;
                end else if (bus.err_detected || bus.err_corrected) begin
                    bad++;
                end
            end else begin
                if (c == 0) bad++;
                if (bus.err_detected || bus.err_corrected || bus.out) bad++;
                if (nval > 0) begin
                    ready = bus.in_ready;
                    break;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [14:0] cw, input bit gaps, input string tag);
        logic [10:0] data;
        logic        det, cor, ready;
        int          nval, bad, p;
        logic [3:0]  syn;
        logic [14:0] fixed;
        send_bits(cw, 15, gaps, 1'b1);
        collect(data, det, cor, nval, bad, ready);
        syn   = poly_mod(cw);
        p     = err_pos(syn);
        fixed = cw;
        if (p >= 4) fixed[p] = ~fixed[p];
        check_eq({tag, ".data"}, 32'(data), 32'(fixed[14:4]));
        check_eq({tag, ".det"}, 32'(det), 32'(syn != 4'd0));
        check_eq({tag, ".cor"}, 32'(cor), 32'(p >= 4));
        check_eq({tag, ".nvalid"}, 32'(nval), 32'd11);
        check_eq({tag, ".glitch"}, 32'(bad), 32'd0);
        check_eq({tag, ".ready"}, 32'(ready), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, ".out"}, 32'(bus.out), 32'd0);
        check_eq({tag, ".err"}, 32'({bus.err_detected, bus.err_corrected}), 32'd0);
    endtask

    initial begin
        logic [10:0] data;
        logic [14:0] cw;
        int          bad;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        run_frame(15'b100000000001001, 1'b0, "clean");
        run_frame(15'b000000000001001, 1'b0, "first_bit");
        run_frame(15'b000000000000010, 1'b0, "parity");
        run_frame(15'b010000000001001, 1'b0, "double");

        for (int p = 4; p < 15; p++) begin
            data = 11'($urandom);
            cw   = encode(data);
            cw[p] = ~cw[p];
            run_frame(cw, 1'b1, $sformatf("pos%0d", p));
        end

        for (int n = 0; n < 40; n++) begin
            int a, b;
            data = 11'($urandom);
            cw   = encode(data);
            case ($urandom_range(0, 3))
                1: begin
                    a = $urandom_range(4, 14);
                    cw[a] = ~cw[a];
                end
                2: begin
                    a = $urandom_range(0, 3);
                    cw[a] = ~cw[a];
                end
                3: begin
                    a = $urandom_range(0, 14);
                    b = (a + $urandom_range(1, 14)) % 15;
                    cw[a] = ~cw[a];
                    cw[b] = ~cw[b];
                end
                default: ;
            endcase
            run_frame(cw, 1'($urandom), $sformatf("rnd%0d", n));
        end

        // Reset in the middle of reception.
        send_bits(encode(11'h5a5), 7, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("rst_recv");
        rst = 1'b0;
        run_frame(encode(11'h3c7), 1'b0, "after_rst_recv");

        // Reset on SEND cycle 5.
        send_bits(encode(11'h6d1) ^ 15'h0400, 15, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("rst_send");
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid || bus.err_detected || bus.err_corrected) bad++;
        end
        check_eq("rst_send.quiet", 32'(bad), 32'd0);
        run_frame(encode(11'h1f0), 1'b0, "after_rst_send");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
